// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

    // Level of rst_n that holds the block in reset.
    localparam logic RstnEnable = 1'b0;

    typedef enum logic [1:0] {
        PcBoot  = 2'd0,
        PcRun   = 2'd1,
        PcFault = 2'd2
    } pc_state_e;

    // Default epoch width and the matching bus type for consumers that
    // do not override EPOCH_W.
    localparam int EpochWDefault = 2;
    typedef logic [EpochWDefault-1:0] epoch_bus_t;

    // Index width for an n-entry channel set; a single channel still
    // needs one bit so that ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rdr_arbiter.sv
// Fixed-priority redirect pick: lowest asserted index wins.
// Latency: purely combinational.
// Backpressure: none; losers are simply not selected.
//
// Ports:
//   req        per-channel request bits
//   targets    packed targets, channel k at [k*ADDR_W +: ADDR_W]
//   pick_vld   any request asserted
//   pick_idx   index of the winning channel
//   pick_tgt   target of the winning channel
module rdr_arbiter
    import pc_gen_pkg::*;
#(
    parameter int NUM_RDR = 2,
    parameter int ADDR_W  = 32,
    localparam int IDX_W  = idx_width(NUM_RDR)
) (
    input  logic [NUM_RDR-1:0]        req,
    input  logic [NUM_RDR*ADDR_W-1:0] targets,
    output logic                      pick_vld,
    output logic [IDX_W-1:0]          pick_idx,
    output logic [ADDR_W-1:0]         pick_tgt
);

    // Walk from the lowest priority upward so the last hit (the lowest
    // index) is the one that sticks.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_tgt = '0;
        for (int k = NUM_RDR - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(k);
                pick_tgt = targets[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with prioritised redirects, hold-time redirect buffer and epoch.
// Latency: redirect or sequential step visible one cycle after the sampling edge.
// Backpressure: PC advances only on pc_valid_o & fetch_ready_i; hold_i freezes PC/state/epoch.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rdr_valid_i     per-channel redirect request (index 0 highest priority)
//   rdr_target_i    packed redirect targets, channel k at [k*ADDR_W +: ADDR_W]
//   hold_i          front-end freeze
//   fetch_ready_i   fetch stage accepts pc_o
//   pc_o            registered fetch address
//   pc_valid_o      pc_o is a fetch request (combinational)
//   epoch_o         registered redirect epoch
//   flush_o         one-cycle pulse after a redirect is applied
//   misalign_o      last applied target was not STEP-aligned
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                NUM_RDR  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                STEP     = 4,
    parameter int                EPOCH_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_RDR-1:0]        rdr_valid_i,
    input  logic [NUM_RDR*ADDR_W-1:0] rdr_target_i,
    input  logic                      hold_i,
    input  logic                      fetch_ready_i,
    output logic [ADDR_W-1:0]         pc_o,
    output logic                      pc_valid_o,
    output logic [EPOCH_W-1:0]        epoch_o,
    output logic                      flush_o,
    output logic                      misalign_o
);

    localparam int                IDX_W      = idx_width(NUM_RDR);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

    pc_state_e          state,    state_nxt;
    logic [ADDR_W-1:0]  pc,       pc_nxt;
    logic [EPOCH_W-1:0] epoch,    epoch_nxt;
    logic               flush,    flush_nxt;
    logic               misalign, misalign_nxt;
    logic               pend_v,   pend_v_nxt;
    logic [IDX_W-1:0]   pend_idx, pend_idx_nxt;
    logic [ADDR_W-1:0]  pend_tgt, pend_tgt_nxt;

    // Live pick across the request channels.
    logic               live_v;
    logic [IDX_W-1:0]   live_idx;
    logic [ADDR_W-1:0]  live_tgt;

    rdr_arbiter #(
        .NUM_RDR (NUM_RDR),
        .ADDR_W  (ADDR_W)
    ) u_live (
        .req      (rdr_valid_i),
        .targets  (rdr_target_i),
        .pick_vld (live_v),
        .pick_idx (live_idx),
        .pick_tgt (live_tgt)
    );

    // Live and pending redirects are folded back onto the channel
    // vector and run through the same priority pick. When both sit on
    // the same channel the live target overwrites the pending one, so
    // a tie goes to the newer request.
    logic [NUM_RDR-1:0]        eff_req;
    logic [NUM_RDR*ADDR_W-1:0] eff_tgts;
    logic                      eff_v;
    logic [IDX_W-1:0]          eff_idx;
    logic [ADDR_W-1:0]         eff_tgt;

    always_comb begin
        eff_req  = '0;
        eff_tgts = '0;
        for (int k = 0; k < NUM_RDR; k++) begin
            if (live_v && (live_idx == IDX_W'(k))) begin
                eff_req[k]                    = 1'b1;
                eff_tgts[k*ADDR_W +: ADDR_W] = live_tgt;
            end else if (pend_v && (pend_idx == IDX_W'(k))) begin
                eff_req[k]                    = 1'b1;
                eff_tgts[k*ADDR_W +: ADDR_W] = pend_tgt;
            end
        end
    end

    rdr_arbiter #(
        .NUM_RDR (NUM_RDR),
        .ADDR_W  (ADDR_W)
    ) u_eff (
        .req      (eff_req),
        .targets  (eff_tgts),
        .pick_vld (eff_v),
        .pick_idx (eff_idx),
        .pick_tgt (eff_tgt)
    );

    // Live request beats or ties the pending one (or nothing is pending):
    // this is exactly the condition for overwriting the buffer under hold.
    logic live_wins;
    assign live_wins = live_v && (eff_idx == live_idx);

    assign pc_valid_o = (state == PcRun) && !hold_i;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        epoch_nxt    = epoch;
        flush_nxt    = 1'b0;
        misalign_nxt = misalign;
        pend_v_nxt   = pend_v;
        pend_idx_nxt = pend_idx;
        pend_tgt_nxt = pend_tgt;

        if (hold_i) begin
            // Only the buffer moves while the front end is frozen.
            if (live_wins) begin
                pend_v_nxt   = 1'b1;
                pend_idx_nxt = live_idx;
                pend_tgt_nxt = live_tgt;
            end
        end else if (eff_v) begin
            pc_nxt     = eff_tgt;
            epoch_nxt  = epoch + EPOCH_W'(1);
            flush_nxt  = 1'b1;
            pend_v_nxt = 1'b0;
            if ((eff_tgt & ALIGN_MASK) != '0) begin
                state_nxt    = PcFault;
                misalign_nxt = 1'b1;
            end else begin
                state_nxt    = PcRun;
                misalign_nxt = 1'b0;
            end
        end else begin
            case (state)
                PcBoot:  state_nxt = PcRun;
                PcRun: begin
                    if (pc_valid_o && fetch_ready_i) begin
                        pc_nxt = pc + STEP_INC;
                    end
                end
                default: ; // FAULT waits for an aligned redirect
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstnEnable) begin
            state    <= PcBoot;
            pc       <= RESET_PC;
            epoch    <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
            pend_v   <= 1'b0;
            pend_idx <= '0;
            pend_tgt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            epoch    <= epoch_nxt;
            flush    <= flush_nxt;
            misalign <= misalign_nxt;
            pend_v   <= pend_v_nxt;
            pend_idx <= pend_idx_nxt;
            pend_tgt <= pend_tgt_nxt;
        end
    end

    assign pc_o       = pc;
    assign epoch_o    = epoch;
    assign flush_o    = flush;
    assign misalign_o = misalign;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  ep;
        logic        fl;
        logic        mi;
        logic        va;
    } obs_t;

    typedef struct packed {
        logic [1:0]  rv;
        logic [31:0] t0;
        logic [31:0] t1;
        logic        hold;
        logic        rdy;
    } stim_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rdr_valid;
    logic [63:0] rdr_target;
    logic        hold;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  epoch;
    logic        flush;
    logic        misalign;

    logic [1:0]  rdr_valid8;
    logic [15:0] rdr_target8;
    logic        hold8;
    logic        fetch_ready8;
    logic [7:0]  pc8;
    logic        pc_valid8;
    logic [1:0]  epoch8;
    logic        flush8;
    logic        misalign8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .NUM_RDR(2), .RESET_PC(32'h0), .STEP(4), .EPOCH_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdr_valid_i   (rdr_valid),
        .rdr_target_i  (rdr_target),
        .hold_i        (hold),
        .fetch_ready_i (fetch_ready),
        .pc_o          (pc),
        .pc_valid_o    (pc_valid),
        .epoch_o       (epoch),
        .flush_o       (flush),
        .misalign_o    (misalign)
    );

    pc_gen #(.ADDR_W(8), .NUM_RDR(2), .RESET_PC(8'h0), .STEP(4), .EPOCH_W(2)) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdr_valid_i   (rdr_valid8),
        .rdr_target_i  (rdr_target8),
        .hold_i        (hold8),
        .fetch_ready_i (fetch_ready8),
        .pc_o          (pc8),
        .pc_valid_o    (pc_valid8),
        .epoch_o       (epoch8),
        .flush_o       (flush8),
        .misalign_o    (misalign8)
    );

    function automatic obs_t mk(input logic [31:0] p, input logic [1:0] ep,
                                input logic fl, input logic mi, input logic va);
        obs_t r;
        r.pc = p; r.ep = ep; r.fl = fl; r.mi = mi; r.va = va;
        return r;
    endfunction

    function automatic stim_t st(input logic [1:0] rv, input logic [31:0] t0,
                                 input logic [31:0] t1, input logic h, input logic r);
        stim_t s;
        s.rv = rv; s.t0 = t0; s.t1 = t1; s.hold = h; s.rdy = r;
        return s;
    endfunction

    function automatic obs_t snap();
        return mk(pc, epoch, flush, misalign, pc_valid);
    endfunction

    function automatic obs_t snap8();
        return mk({24'h0, pc8}, epoch8, flush8, misalign8, pc_valid8);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h ep=%0d fl=%b mis=%b vld=%b", o.pc, o.ep, o.fl, o.mi, o.va);
    endfunction

    task automatic drive(input stim_t s);
        rdr_valid   = s.rv;
        rdr_target  = {s.t1, s.t0};
        hold        = s.hold;
        fetch_ready = s.rdy;
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        rst_n = 1'b0;
        drive(st(2'b00, 0, 0, 1'b0, 1'b0));
        rdr_valid8 = 2'b00; rdr_target8 = '0; hold8 = 1'b0; fetch_ready8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e.name = "reset_state"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        e.name = "reset_state8"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        e = sb.pop_front(); o = snap8(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        checks++;
        if (dut.pend_v !== 1'b0) begin
            errors++; $display("FAIL reset_pend: got pend_v=%b, expected 0", dut.pend_v);
        end
        rst_n = 1'b1;
        #1;
        e.name = "cycle0"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
    endtask

    task automatic test_boot();
        stim_t s[4];
        obs_t  x[4];
        exp_t  e;
        obs_t  o;
        s = '{st(2'b00, 0, 0, 0, 0), st(2'b00, 0, 0, 0, 1), st(2'b00, 0, 0, 0, 1), st(2'b00, 0, 0, 0, 1)};
        x = '{mk(32'h0, 0, 0, 0, 1), mk(32'h4, 0, 0, 0, 1), mk(32'h8, 0, 0, 0, 1), mk(32'hC, 0, 0, 0, 1)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            e.name = "boot"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s[2];
        obs_t  x[2];
        exp_t  e;
        obs_t  o;
        s = '{st(2'b11, 32'h100, 32'h200, 0, 0), st(2'b00, 0, 0, 0, 0)};
        x = '{mk(32'h100, 1, 1, 0, 1), mk(32'h100, 1, 0, 0, 1)};
        for (int i = 0; i < 2; i++) begin
            drive(s[i]);
            e.name = "simultaneous"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_hold_buffer();
        stim_t s[8];
        obs_t  x[8];
        exp_t  e;
        obs_t  o;
        s = '{st(2'b10, 0, 32'h200, 1, 1), st(2'b01, 32'h300, 0, 1, 0),
              st(2'b00, 0, 0, 0, 0),       st(2'b00, 0, 0, 0, 0),
              st(2'b01, 32'h380, 0, 1, 0), st(2'b10, 0, 32'h200, 1, 0),
              st(2'b00, 0, 0, 0, 0),       st(2'b00, 0, 0, 0, 0)};
        x = '{mk(32'h100, 1, 0, 0, 0), mk(32'h100, 1, 0, 0, 0),
              mk(32'h300, 2, 1, 0, 1), mk(32'h300, 2, 0, 0, 1),
              mk(32'h300, 2, 0, 0, 0), mk(32'h300, 2, 0, 0, 0),
              mk(32'h380, 3, 1, 0, 1), mk(32'h380, 3, 0, 0, 1)};
        for (int i = 0; i < 8; i++) begin
            drive(s[i]);
            e.name = "hold_buffer"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_redirect_vs_handshake();
        stim_t s[4];
        obs_t  x[4];
        exp_t  e;
        obs_t  o;
        s = '{st(2'b01, 32'h40, 0, 0, 0), st(2'b10, 0, 32'h80, 0, 1),
              st(2'b00, 0, 0, 0, 1),      st(2'b00, 0, 0, 0, 0)};
        // Epoch wraps 3 -> 0 on the first redirect.
        x = '{mk(32'h40, 0, 1, 0, 1), mk(32'h80, 1, 1, 0, 1),
              mk(32'h84, 1, 0, 0, 1), mk(32'h84, 1, 0, 0, 1)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            e.name = "redirect_vs_handshake"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
    endtask

    task automatic test_misalign();
        stim_t s[5];
        obs_t  x[5];
        exp_t  e;
        obs_t  o;
        s = '{st(2'b01, 32'h102, 0, 0, 0), st(2'b00, 0, 0, 0, 1), st(2'b00, 0, 0, 0, 1),
              st(2'b10, 0, 32'h200, 0, 1), st(2'b00, 0, 0, 0, 1)};
        x = '{mk(32'h102, 2, 1, 1, 0), mk(32'h102, 2, 0, 1, 0), mk(32'h102, 2, 0, 1, 0),
              mk(32'h200, 3, 1, 0, 1), mk(32'h204, 3, 0, 0, 1)};
        for (int i = 0; i < 5; i++) begin
            drive(s[i]);
            e.name = "misalign"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
        drive(st(2'b00, 0, 0, 0, 0));
    endtask

    task automatic test_wrap8();
        logic [1:0] rv[3];
        logic [7:0] tg[3];
        logic       rd[3];
        obs_t       x[3];
        exp_t       e;
        obs_t       o;
        rv = '{2'b01, 2'b00, 2'b00};
        tg = '{8'hFC, 8'h00, 8'h00};
        rd = '{1'b0, 1'b1, 1'b1};
        x  = '{mk(32'hFC, 1, 1, 0, 1), mk(32'h00, 1, 0, 0, 1), mk(32'h04, 1, 0, 0, 1)};
        for (int i = 0; i < 3; i++) begin
            rdr_valid8 = rv[i]; rdr_target8 = {8'h00, tg[i]}; fetch_ready8 = rd[i];
            e.name = "wrap8"; e.v = x[i]; sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = snap8(); checks++;
            if (o !== e.v) begin
                errors++; $display("FAIL %s[%0d]: got %s, expected %s", e.name, i, fmt(o), fmt(e.v));
            end
        end
        rdr_valid8 = 2'b00; fetch_ready8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        drive(st(2'b10, 0, 32'h200, 1, 0));
        e.name = "reset_mid_capture"; e.v = mk(32'h204, 3, 0, 0, 0); sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        checks++;
        if (dut.pend_v !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pend_set: got pend_v=%b, expected 1", dut.pend_v);
        end
        rst_n = 1'b0;
        #2;
        e.name = "reset_mid_async"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        checks++;
        if (dut.pend_v !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pend_clear: got pend_v=%b, expected 0", dut.pend_v);
        end
        drive(st(2'b00, 0, 0, 0, 0));
        rst_n = 1'b1;
        // A surviving pending redirect would show up here as pc=0x200.
        e.name = "reset_mid_reboot"; e.v = mk(0, 0, 0, 0, 1); sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
    endtask

    task automatic test_hold_boot();
        exp_t e;
        obs_t o;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        drive(st(2'b00, 0, 0, 1, 0));
        rst_n = 1'b1;
        e.name = "hold_boot_frozen"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        // Releasing hold must not expose a valid PC: still in BOOT.
        hold = 1'b0;
        #1;
        e.name = "hold_boot_still_boot"; e.v = mk(0, 0, 0, 0, 0); sb.push_back(e);
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
        e.name = "hold_boot_run"; e.v = mk(0, 0, 0, 0, 1); sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front(); o = snap(); checks++;
        if (o !== e.v) begin
            errors++; $display("FAIL %s: got %s, expected %s", e.name, fmt(o), fmt(e.v));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_boot();
        test_simultaneous();
        test_hold_buffer();
        test_redirect_vs_handshake();
        test_misalign();
        test_wrap8();
        test_reset_mid();
        test_hold_boot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end, successor to the single-width two-source PC register. It produces the fetch address with a valid/ready handshake and accepts NUM_RDR prioritised redirect channels (ID jump, EX branch, exception/trap, …). Redirects arriving under a front-end hold are buffered and applied when the hold is released. Every accepted redirect advances an epoch counter so the fetch and decode stages can drop stale instructions.

## Interface
- ADDR_W, 32: PC width in bits.
- NUM_RDR, 2: number of redirect channels; index 0 has the highest priority.
- RESET_PC, 0: PC value after reset (ADDR_W bits).
- STEP, 4: sequential increment in bytes; must be a power of two; also the alignment requirement.
- EPOCH_W, 2: epoch counter width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdr_valid_i  in  NUM_RDR  per-channel redirect request, sampled at posedge.
- rdr_target_i  in  NUM_RDR*ADDR_W  packed targets; channel k occupies [k*ADDR_W +: ADDR_W].
- hold_i  in  1  front-end freeze (replaces the old stall[0]).
- fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
- pc_o  out  ADDR_W  current fetch address, registered.
- pc_valid_o  out  1  pc_o is a fetch request.
- epoch_o  out  EPOCH_W  redirect epoch, registered.
- flush_o  out  1  one-cycle pulse in the cycle after a redirect is applied.
- misalign_o  out  1  the last applied target was not STEP-aligned.

## Operation
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- Live pick: the lowest-index asserted rdr_valid_i, giving live_idx and live_tgt.
- Pending buffer: pend_v, pend_idx, pend_tgt.
- Hold rules (hold_i=1):
  - A live redirect is captured into the pending buffer when pend_v=0, or when live_idx <= pend_idx.
  - Otherwise the live redirect is dropped.
  - pc_o, state and epoch are frozen.
- No hold (hold_i=0): the effective redirect is the candidate with the lower index among live and pending; a tie goes to live. If a redirect is effective:
  - pc_o <= target.
  - epoch_o <= epoch_o + 1, modulo 2^EPOCH_W.
  - flush_o <= 1.
  - pend_v <= 0.
  - If target & (STEP-1) != 0: state <= FAULT, misalign_o <= 1. Otherwise: state <= RUN, misalign_o <= 0.
- No redirect, state RUN, pc_valid_o and fetch_ready_i both high: pc_o <= pc_o + STEP, wrapping modulo 2^ADDR_W.
- BOOT with no redirect: after one cycle go to RUN, with pc_o still RESET_PC. A redirect in BOOT is applied as above.
- FAULT: pc_o holds the misaligned target; it is left only by an aligned redirect.
- pc_valid_o = (state==RUN) & ~hold_i. This is combinational and is the only non-registered output.

## Timing
- Reset values: pc_o=RESET_PC, pc_valid_o=0, epoch_o=0, flush_o=0, misalign_o=0, pend_v=0, state=BOOT.
- rst_n asserted mid-operation clears everything immediately, including the pending buffer.
- First posedge after rst_n deasserts: BOOT→RUN, so pc_valid_o=1 from the next cycle.
- Redirect latency is one cycle: a request sampled at edge N gives pc_o=target and flush_o=1 after edge N. The redirected PC is never the PC accepted at edge N.
- Redirect in the same cycle as a fetch handshake: the redirect wins and the increment is discarded.
- Buffered redirect: applied at the first posedge with hold_i=0; flush_o follows one cycle later.
- fetch_ready_i without pc_valid_o has no effect.
- hold_i during BOOT: stays in BOOT.

## Structure
- defines.vh gains:
  - `RstnEnable 1'b0.
  - State encodings PcBoot, PcRun, PcFault.
  - `EpochBus, sized from EPOCH_W default.
- Sub-module rdr_arbiter (parameter NUM_RDR, ADDR_W): combinational fixed-priority pick returning valid, index ($clog2 width, minimum 1) and target. It is reused for the live/pending comparison.
- Top module: state register, pending buffer, PC/epoch datapath.

## Test plan
- Reset and boot: rst_n low, then high at edge 0 → pc_valid_o=0 in cycle 0, then pc_o=0x0, valid=1. With fetch_ready_i=1 for 3 cycles → 0x4, 0x8, 0xC.
- Simultaneous redirects: ch0→0x100 and ch1→0x200 in one cycle → pc_o=0x100, epoch 0→1, flush_o pulses one cycle.
- Hold buffering:
  - hold_i=1, ch1→0x200, then ch0→0x300 on the next cycle, then release → pc_o=0x300, epoch+1 only once.
  - Reverse order (ch0 first, then ch1) → 0x300 kept.
- Redirect vs handshake: pc_o=0x40, fetch_ready_i=1 and ch1→0x80 on the same edge → pc_o=0x80, not 0x44.
- Misalignment: ch0→0x102 → misalign_o=1, pc_valid_o=0, state FAULT. Handshakes are ignored. ch1→0x200 → RUN, misalign_o=0.
- Wrap and reset mid-operation:
  - ADDR_W=8, pc_o=0xFC, handshake → 0x00.
  - Epoch 3 plus a redirect → 0.
  - rst_n pulsed while pend_v=1 → pend_v=0 and pc_o=RESET_PC asynchronously.
